// File: rtl/fb_sdram_pkg.sv
// fb_sdram_pkg: shared types and address math for the frame-buffer SDRAM writer.
package fb_sdram_pkg;

    typedef enum logic {IDLE, REQ} wr_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } fb_word_t;

    function automatic logic [31:0] word_addr(input int unsigned base, input int unsigned h_res,
                                              input int unsigned cx, input int unsigned cy);
        return base + cy * (h_res / 2) + (cx >> 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO; also exposes the entry behind the head.
module sync_fifo #(
    parameter type T = logic [7:0],
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  T              wr_data,
    input  logic          pop,
    output T              rd_data,
    output T              rd_nxt,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    T mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign rd_nxt  = mem_q[rd_ptr_q + AW'(1)];
    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;

    always_ff @(posedge clk)
        if (push) mem_q[wr_ptr_q] <= wr_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fb_sdram_writer.sv
// fb_sdram_writer: packs RGB565 pixel pairs into 32-bit words and issues single-word SDRAM writes.
module fb_sdram_writer
    import fb_sdram_pkg::*;
#(
    parameter int BIT_WIDTH  = 10,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_vde,
    input  logic [BIT_WIDTH-1:0]  i_cx,
    input  logic [BIT_WIDTH-1:0]  i_cy,
    input  logic [15:0]           i_rgb,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_we,
    output logic                  o_req,
    input  logic                  i_ack,
    output logic                  o_overflow,
    output logic                  o_frame_done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_t state_q, state_d;
    logic [15:0] lo_q, lo_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic req_q, req_d, last_q, last_d, ovf_q, ovf_d, done_q, done_d, avail_q, avail_d;
    logic accept, push_req, push, pop, full, empty, unused_addr_bits;
    logic [CW-1:0] count;
    fb_word_t in_word, head, nxt, load;

    assign accept   = i_vde && int'(i_cx) < H_RES && int'(i_cy) < V_RES;
    assign push_req = accept && i_cx[0];
    assign pop      = state_q == REQ && i_ack;
    assign push     = push_req && (!full || pop);
    assign in_word  = '{addr: word_addr(BASE_ADDR, H_RES, 32'(i_cx), 32'(i_cy)),
                        data: {i_rgb, lo_q},
                        last: int'(i_cx) == H_RES - 1 && int'(i_cy) == V_RES - 1};
    assign unused_addr_bits = ^{head.addr, nxt.addr, in_word.addr};

    sync_fifo #(.T(fb_word_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .wr_data(in_word), .pop(pop),
        .rd_data(head), .rd_nxt(nxt), .full(full), .empty(empty), .count(count)
    );

    // avail_q delays the idle launch one cycle; on an ack the follow-up word comes from
    // the entry behind the head, or straight from the input if it is arriving this edge.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        req_d   = req_q;
        last_d  = last_q;
        lo_d    = (accept && !i_cx[0]) ? i_rgb : lo_q;
        ovf_d   = ovf_q || (push_req && !push);
        done_d  = pop && last_q;
        avail_d = !empty;
        load    = (state_q == IDLE) ? head : (count > CW'(1)) ? nxt : in_word;
        if ((state_q == IDLE && avail_q && !empty) || (pop && (count > CW'(1) || push))) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = load.addr[ADDR_WIDTH-1:0];
            data_d  = load.data;
            last_d  = load.last;
        end else if (pop) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            avail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            req_q   <= req_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            avail_q <= avail_d;
        end
    end

    assign o_addr       = addr_q;
    assign o_data       = data_q;
    assign o_req        = req_q;
    assign o_we         = req_q;
    assign o_overflow   = ovf_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_fb_sdram_writer.sv
// tb_fb_sdram_writer: scenario tasks plus a randomized run scored against a queue-based pixel/word model.
module tb_fb_sdram_writer;
    localparam int H = 640;
    localparam int V = 480;
    localparam int DEPTH = 16;

    logic clk = 0, rst_n = 0, i_vde = 0, i_ack = 0;
    logic [9:0] i_cx = 0, i_cy = 0;
    logic [15:0] i_rgb = 0;
    logic [17:0] o_addr;
    logic [31:0] o_data;
    logic o_we, o_req, o_overflow, o_frame_done;

    fb_sdram_writer dut (
        .clk(clk), .rst_n(rst_n), .i_vde(i_vde), .i_cx(i_cx), .i_cy(i_cy), .i_rgb(i_rgb),
        .o_addr(o_addr), .o_data(o_data), .o_we(o_we), .o_req(o_req), .i_ack(i_ack),
        .o_overflow(o_overflow), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; logic [31:0] data; bit last;} word_t;
    word_t mq[$], exp_q[$], act_q[$];
    logic [15:0] m_lo;
    bit m_ovf, m_done;
    int exp_done, act_done, checks, errors;

    // One clock: drive at the falling edge, advance the model, sample at the next falling edge.
    task automatic step(input bit vde, input int cx, input int cy, input logic [15:0] rgb, input bit ack);
        word_t w;
        i_vde = vde; i_cx = 10'(cx); i_cy = 10'(cy); i_rgb = rgb; i_ack = ack;
        m_done = 0;
        if (ack && o_req) begin
            act_q.push_back('{int'(o_addr), o_data, 1'b0});
            if (mq.size() > 0) begin
                w = mq.pop_front();
                m_done = w.last;
                exp_q.push_back(w);
            end else exp_q.push_back('{-1, 32'h0, 1'b0});
        end
        if (vde && cx >= 0 && cx < H && cy >= 0 && cy < V) begin
            if (cx % 2 == 0) m_lo = rgb;
            else if (mq.size() < DEPTH) mq.push_back('{cy * (H / 2) + cx / 2, {rgb, m_lo}, cx == H - 1 && cy == V - 1});
            else m_ovf = 1;
        end
        @(posedge clk);
        @(negedge clk);
        if (o_frame_done) act_done++;
        if (m_done) exp_done++;
    endtask

    task automatic do_reset();
        i_vde = 0; i_ack = 0; rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        mq.delete(); exp_q.delete(); act_q.delete();
        m_lo = 0; m_ovf = 0; m_done = 0; exp_done = 0; act_done = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_req, o_we} !== 2'b00) begin errors++; $display("FAIL reset_req: got %b want 00", {o_req, o_we}); end
        checks++;
        if ({o_addr, o_data, o_overflow, o_frame_done} !== '0)
            begin errors++; $display("FAIL reset_outs: got addr=%0h data=%0h ovf=%b done=%b want all 0", o_addr, o_data, o_overflow, o_frame_done); end
    endtask

    task automatic test_single_pair();
        do_reset();
        step(1, 0, 0, 16'h1111, 0);
        step(1, 1, 0, 16'h2222, 0);
        checks++;
        if (o_req !== 0) begin errors++; $display("FAIL pair_req_t: got %b want 0", o_req); end
        step(0, 0, 0, 0, 0);
        checks++;
        if (o_req !== 0) begin errors++; $display("FAIL pair_req_t1: got %b want 0", o_req); end
        step(0, 0, 0, 0, 0);
        checks++;
        if ({o_req, o_we} !== 2'b11 || o_addr !== 0 || o_data !== 32'h2222_1111)
            begin errors++; $display("FAIL pair_req_t2: got req=%b we=%b addr=%0h data=%0h want 1 1 0 22221111", o_req, o_we, o_addr, o_data); end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (o_req !== 1 || o_addr !== 0 || o_data !== 32'h2222_1111)
            begin errors++; $display("FAIL pair_hold: got req=%b addr=%0h data=%0h want 1 0 22221111", o_req, o_addr, o_data); end
        step(0, 0, 0, 0, 1);
        checks++;
        if (o_req !== 0 || o_we !== 0) begin errors++; $display("FAIL pair_drop: got req=%b we=%b want 0 0", o_req, o_we); end
        checks++;
        if (act_q.size() != 1 || exp_q.size() != 1 || act_q[0].data !== exp_q[0].data || act_q[0].addr != exp_q[0].addr)
            begin errors++; $display("FAIL pair_delivered: got %0d words want 1 matching model", act_q.size()); end
    endtask

    task automatic test_address_math();
        do_reset();
        step(1, 638, 479, 16'hAAAA, 0);
        step(1, 639, 479, 16'hBBBB, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (o_req !== 1 || o_addr !== 18'd153599 || o_data !== 32'hBBBB_AAAA)
            begin errors++; $display("FAIL addr_math: got req=%b addr=%0d data=%0h want 1 153599 bbbbaaaa", o_req, o_addr, o_data); end
        step(0, 0, 0, 0, 1);
        checks++;
        if (o_frame_done !== 1 || o_req !== 0) begin errors++; $display("FAIL frame_done_pulse: got done=%b req=%b want 1 0", o_frame_done, o_req); end
        step(0, 0, 0, 0, 0);
        checks++;
        if (o_frame_done !== 0) begin errors++; $display("FAIL frame_done_width: got %b want 0", o_frame_done); end
    endtask

    task automatic test_out_of_range();
        bit seen = 0;
        step(1, 640, 0, 16'h1234, 0);
        step(1, 641, 0, 16'h4321, 0);
        step(1, 0, 480, 16'h5555, 0);
        step(1, 1, 480, 16'h6666, 0);
        step(0, 0, 0, 16'h7777, 0);
        repeat (4) begin
            step(0, 0, 0, 0, 0);
            seen |= o_req | o_overflow;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL oor_ignored: got req/ovf activity=%b want 0", seen); end
        step(1, 1, 0, 16'hCCCC, 0);
        for (int k = 0; k < 10 && o_req !== 1; k++) step(0, 0, 0, 0, 0);
        checks++;
        if (o_req !== 1 || o_data !== 32'hCCCC_AAAA || o_addr !== 0)
            begin errors++; $display("FAIL unpaired_odd: got req=%b addr=%0h data=%0h want 1 0 ccccaaaa", o_req, o_addr, o_data); end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [4];
        do_reset();
        for (int w = 0; w < 4; w++) begin
            d[w] = $urandom;
            step(1, 2 * w, 0, d[w][15:0], 0);
            step(1, 2 * w + 1, 0, d[w][31:16], 0);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_req !== 1 || o_addr !== 18'(k) || o_data !== d[k])
                begin errors++; $display("FAIL b2b_word%0d: got req=%b addr=%0h data=%0h want 1 %0h %0h", k, o_req, o_addr, o_data, k, d[k]); end
            step(0, 0, 0, 0, 1);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (o_req !== 0 || act_q.size() != 4) begin errors++; $display("FAIL b2b_end: got req=%b words=%0d want 0 4", o_req, act_q.size()); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int cx = 0; cx < 40; cx++) begin
            step(1, cx, 0, 16'($urandom), 0);
            if (cx == 31) begin
                checks++;
                if (o_overflow !== 0) begin errors++; $display("FAIL ovf_early: got %b want 0", o_overflow); end
            end
            if (cx == 33) begin
                checks++;
                if (o_overflow !== 1) begin errors++; $display("FAIL ovf_set: got %b want 1", o_overflow); end
            end
        end
        for (int k = 0; k < 60; k++) step(0, 0, 0, 0, o_req);
        checks++;
        if (act_q.size() != 16 || o_overflow !== 1) begin errors++; $display("FAIL ovf_count: got %0d words ovf=%b want 16 1", act_q.size(), o_overflow); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i].addr != i || act_q[i].data !== exp_q[i].data)
                begin errors++; $display("FAIL ovf_word%0d: got %0h/%0h want %0h/%0h", i, act_q[i].addr, act_q[i].data, i, exp_q[i].data); end
        end
    endtask

    task automatic test_reset_during_req();
        bit seen = 0;
        do_reset();
        step(1, 638, 479, 16'h0F0F, 0);
        step(1, 639, 479, 16'hF0F0, 0);
        for (int k = 0; k < 10 && o_req !== 1; k++) step(0, 0, 0, 0, 0);
        checks++;
        if (o_req !== 1) begin errors++; $display("FAIL rst_req_setup: got %b want 1", o_req); end
        do_reset();
        checks++;
        if ({o_req, o_we, o_overflow, o_frame_done} !== 4'b0 || o_addr !== 0 || o_data !== 0)
            begin errors++; $display("FAIL rst_in_req: got req=%b addr=%0h data=%0h want all 0", o_req, o_addr, o_data); end
        repeat (4) begin
            step(0, 0, 0, 0, 1);
            seen |= o_req | o_frame_done;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rst_stale_ack: got activity=%b want 0", seen); end
    endtask

    task automatic test_random();
        int cx = H - 160, cy = V - 1;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(15) == 0) step(1, H + int'($urandom_range(1)), cy, 16'($urandom), o_req && $urandom_range(1));
            else if ($urandom_range(7) == 0) step(0, cx, cy, 16'($urandom), o_req && $urandom_range(1));
            else begin
                step(1, cx, cy, 16'($urandom), o_req && $urandom_range(1));
                cx++;
                if (cx == H) begin cx = 0; cy = (cy + 1) % V; end
            end
        end
        for (int k = 0; k < 80; k++) step(0, 0, 0, 0, o_req);
        checks++;
        if (act_q.size() != exp_q.size() || mq.size() != 0)
            begin errors++; $display("FAIL rnd_count: got %0d words want %0d (model left %0d)", act_q.size(), exp_q.size(), mq.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i].addr != exp_q[i].addr || act_q[i].data !== exp_q[i].data)
                begin errors++; $display("FAIL rnd_word%0d: got %0h/%0h want %0h/%0h", i, act_q[i].addr, act_q[i].data, exp_q[i].addr, exp_q[i].data); end
        end
        checks++;
        if (o_overflow !== m_ovf || act_done != exp_done)
            begin errors++; $display("FAIL rnd_flags: got ovf=%b done=%0d want %b %0d", o_overflow, act_done, m_ovf, exp_done); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_pair();
        test_address_math();
        test_out_of_range();
        test_back_to_back();
        test_overflow();
        test_reset_during_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
